// File: rtl/md_defs_pkg.sv
// Shared multiply/divide definitions: op codes, default latencies and unit state type.
// Used by md_unit and by the decoder that produces md_op/start.
package md_defs;

   localparam int unsigned MD_OP_W = 4;

   localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
   localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
   localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
   localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
   localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
   localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
   localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
   localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
   localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd8;

   localparam int unsigned MD_MULT_CYCLES = 5;
   localparam int unsigned MD_DIV_CYCLES  = 10;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Optional macro MDU_MADD_EN enables MADD/MSUB accumulate into {HI,LO}.
module md_unit
   import md_defs::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req,
   input  logic               start,
   input  logic [MD_OP_W-1:0] md_op,
   input  logic [31:0]        a,
   input  logic [31:0]        b,
   output logic               busy,
   output logic [31:0]        hi,
   output logic [31:0]        lo
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e          r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_busy;
   logic [31:0]        r_hi, r_lo, w_hi_nxt, w_lo_nxt;
   logic [MD_OP_W-1:0] r_op, w_op_nxt;
   logic [31:0]        r_a, r_b, w_a_nxt, w_b_nxt;

   logic               w_is_mul, w_is_div;
   logic [63:0]        w_prod_s, w_prod_u, w_hilo;
   logic               w_div_ovf, w_div_zero;
   logic [31:0]        w_div_b, w_quo_s, w_rem_s, w_quo_u, w_rem_u;

`ifdef MDU_MADD_EN
   assign w_is_mul = start && (md_op == MD_MULT || md_op == MD_MULTU ||
                               md_op == MD_MADD || md_op == MD_MSUB);
`else
   assign w_is_mul = start && (md_op == MD_MULT || md_op == MD_MULTU);
`endif
   assign w_is_div = start && (md_op == MD_DIV || md_op == MD_DIVU);

   // Result datapath works only from operands latched at accept.
   assign w_prod_s   = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
   assign w_prod_u   = {32'd0, r_a} * {32'd0, r_b};
   assign w_hilo     = {r_hi, r_lo};
   assign w_div_zero = (r_b == 32'd0);
   // 0x80000000 / -1 overflows; dividing by 1 yields the required quotient and zero remainder.
   assign w_div_ovf  = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
   assign w_div_b    = w_div_ovf ? 32'd1 : r_b;
   assign w_quo_s    = $signed(r_a) / $signed(w_div_b);
   assign w_rem_s    = $signed(r_a) % $signed(w_div_b);
   assign w_quo_u    = r_a / r_b;
   assign w_rem_u    = r_a % r_b;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      w_op_nxt    = r_op;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      case (r_state)
         MD_IDLE: begin
            if (!req) begin
               if (w_is_mul || w_is_div) begin
                  w_state_nxt = MD_RUN;
                  w_cnt_nxt   = w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  w_op_nxt    = md_op;
                  w_a_nxt     = a;
                  w_b_nxt     = b;
               end else if (md_op == MD_MTHI) begin
                  w_hi_nxt = a;
               end else if (md_op == MD_MTLO) begin
                  w_lo_nxt = a;
               end
            end
         end
         MD_RUN: begin
            // req is deliberately ignored here: the in-flight op belongs to an older instruction.
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = MD_IDLE;
               case (r_op)
                  MD_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
                  MD_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
`ifdef MDU_MADD_EN
                  MD_MADD:  {w_hi_nxt, w_lo_nxt} = w_hilo + w_prod_s;
                  MD_MSUB:  {w_hi_nxt, w_lo_nxt} = w_hilo - w_prod_s;
`endif
                  MD_DIV: begin
                     if (!w_div_zero) begin
                        w_lo_nxt = w_quo_s;
                        w_hi_nxt = w_rem_s;
                     end
                  end
                  MD_DIVU: begin
                     if (!w_div_zero) begin
                        w_lo_nxt = w_quo_u;
                        w_hi_nxt = w_rem_u;
                     end
                  end
                  default: begin
                     w_hi_nxt = r_hi;
                     w_lo_nxt = r_lo;
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_op    <= MD_NONE;
         r_a     <= '0;
         r_b     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_cnt_nxt != '0);
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
         r_op    <= w_op_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
      end
   end

   assign busy = r_busy;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus random traffic against a cycle-level reference model.
// Model follows MDU_MADD_EN the same way the design does.
module tb_md_unit;
   import md_defs::*;

   logic        clk = 1'b0;
   logic        reset, req, start;
   logic [3:0]  md_op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   always #5 clk = ~clk;

   md_unit #(
      .MULT_CYCLES(MD_MULT_CYCLES),
      .DIV_CYCLES (MD_DIV_CYCLES)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .req  (req),
      .start(start),
      .md_op(md_op),
      .a    (a),
      .b    (b),
      .busy (busy),
      .hi   (hi),
      .lo   (lo)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: an op accepted at edge k commits at edge k+N; busy after edges k..k+N-1.
   int          edge_k = 0;
   bit          m_active = 1'b0;
   int          m_acc_edge = 0;
   int          m_lat = 0;
   bit          m_wr = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [31:0] m_res_hi, m_res_lo;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at edge %0d: got %08h expected %08h", tag, edge_k, got, exp);
   endtask

   task automatic model_accept(input int lat, input logic [63:0] res, input bit wr);
      m_active   = 1'b1;
      m_acc_edge = edge_k;
      m_lat      = lat;
      m_res_hi   = res[63:32];
      m_res_lo   = res[31:0];
      m_wr       = wr;
   endtask

   task automatic model_edge();
      longint      ps;
      logic [63:0] pu;
      int          sa, sb;
      ps = longint'(int'(a)) * longint'(int'(b));
      pu = {32'd0, a} * {32'd0, b};
      sa = int'(a);
      sb = int'(b);
      if (reset) begin
         m_active = 1'b0;
         m_hi     = '0;
         m_lo     = '0;
      end else if (m_active) begin
         if (edge_k == m_acc_edge + m_lat) begin
            if (m_wr) begin
               m_hi = m_res_hi;
               m_lo = m_res_lo;
            end
            m_active = 1'b0;
         end
      end else if (!req) begin
         if (start && md_op == MD_MULT) model_accept(MD_MULT_CYCLES, 64'(ps), 1'b1);
         else if (start && md_op == MD_MULTU) model_accept(MD_MULT_CYCLES, pu, 1'b1);
         else if (start && md_op == MD_DIV) begin
            if (sb == 0) model_accept(MD_DIV_CYCLES, 64'd0, 1'b0);
            else if (sa == int'(32'h8000_0000) && sb == -1)
               model_accept(MD_DIV_CYCLES, {32'd0, 32'h8000_0000}, 1'b1);
            else model_accept(MD_DIV_CYCLES, {32'(sa % sb), 32'(sa / sb)}, 1'b1);
         end else if (start && md_op == MD_DIVU) begin
            if (b == 32'd0) model_accept(MD_DIV_CYCLES, 64'd0, 1'b0);
            else model_accept(MD_DIV_CYCLES, {a % b, a / b}, 1'b1);
         end
`ifdef MDU_MADD_EN
         else if (start && md_op == MD_MADD)
            model_accept(MD_MULT_CYCLES, {m_hi, m_lo} + 64'(ps), 1'b1);
         else if (start && md_op == MD_MSUB)
            model_accept(MD_MULT_CYCLES, {m_hi, m_lo} - 64'(ps), 1'b1);
`endif
         else if (md_op == MD_MTHI) m_hi = a;
         else if (md_op == MD_MTLO) m_lo = a;
      end
   endtask

   task automatic step(input logic rst, input logic rq, input logic st,
                       input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb);
      reset = rst; req = rq; start = st; md_op = op; a = aa; b = bb;
      @(posedge clk);
      model_edge();
      #1;
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      edge_k++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, MD_NONE, 32'd0, 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b1; req = 1'b0; start = 1'b0; md_op = MD_NONE; a = '0; b = '0;
      @(negedge clk);
      step(1'b1, 1'b0, 1'b0, MD_NONE, 32'd0, 32'd0);
      step(1'b1, 1'b0, 1'b0, MD_NONE, 32'd0, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);

      step(1'b0, 1'b0, 1'b1, MD_MULT, 32'hFFFF_FFFF, 32'd2);
      chk("mult_busy_first", {31'd0, busy}, 32'd1);
      idle(4);
      chk("mult_busy_last", {31'd0, busy}, 32'd1);
      idle(1);
      chk("mult_done", {31'd0, busy}, 32'd0);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFE);

      step(1'b0, 1'b0, 1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      idle(5);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);

      step(1'b0, 1'b0, 1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
      idle(9);
      chk("div_busy_last", {31'd0, busy}, 32'd1);
      idle(1);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      step(1'b0, 1'b0, 1'b1, MD_DIVU, 32'd7, 32'd0);
      idle(10);
      chk("div0_hi", hi, 32'hFFFF_FFFF);
      chk("div0_lo", lo, 32'hFFFF_FFFD);

      step(1'b0, 1'b0, 1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      idle(10);
      chk("divovf_lo", lo, 32'h8000_0000);
      chk("divovf_hi", hi, 32'd0);

      step(1'b0, 1'b0, 1'b0, MD_MTHI, 32'h1234_5678, 32'd0);
      chk("mthi_hi", hi, 32'h1234_5678);
      chk("mthi_busy", {31'd0, busy}, 32'd0);

      step(1'b0, 1'b0, 1'b1, MD_MULTU, 32'd3, 32'd5);
      step(1'b0, 1'b0, 1'b0, MD_MTLO, 32'hDEAD_BEEF, 32'd0);
      idle(4);
      chk("mtlo_busy_lo", lo, 32'd15);

      step(1'b0, 1'b1, 1'b1, MD_MULT, 32'd9, 32'd9);
      chk("req_start_busy", {31'd0, busy}, 32'd0);
      chk("req_start_lo", lo, 32'd15);

      step(1'b0, 1'b0, 1'b1, MD_MULTU, 32'd6, 32'd7);
      idle(2);
      step(1'b0, 1'b1, 1'b0, MD_MTLO, 32'h5555_5555, 32'd0);
      idle(2);
      chk("req_inflight_lo", lo, 32'd42);

      step(1'b0, 1'b0, 1'b1, MD_DIVU, 32'd100, 32'd7);
      idle(3);
      step(1'b1, 1'b0, 1'b0, MD_NONE, 32'd0, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_hi", hi, 32'd0);
      idle(12);
      chk("rst_mid_lo", lo, 32'd0);

      step(1'b0, 1'b0, 1'b0, MD_MTHI, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b0, MD_MTLO, 32'hFFFF_FFFF, 32'd0);
      step(1'b0, 1'b0, 1'b1, MD_MADD, 32'd1, 32'd1);
      idle(5);
`ifdef MDU_MADD_EN
      chk("madd_hi", hi, 32'd1);
      chk("madd_lo", lo, 32'd0);
`else
      chk("madd_off_hi", hi, 32'd0);
      chk("madd_off_lo", lo, 32'hFFFF_FFFF);
`endif

      for (int i = 0; i < 3000; i++) begin
         logic        r_rst, r_req, r_st;
         logic [3:0]  r_op;
         logic [31:0] r_a, r_b;
         r_rst = ($urandom_range(0, 99) < 2);
         r_req = ($urandom_range(0, 7) == 0);
         r_st  = ($urandom_range(0, 3) != 0);
         r_op  = 4'($urandom_range(0, 9));
         r_a   = pick();
         r_b   = ($urandom_range(0, 15) == 0) ? 32'd0 : pick();
         step(r_rst, r_req, r_st, r_op, r_a, r_b);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
